// File: rtl/baser_pkg.sv
// ---------------------------------------------------------------------------
// baser_pkg
// Shared constants and types for the 64b/66b BASE-R transmit path:
// MII control characters, 7-bit block control codes, block-type fields,
// sync headers, the transmit state enum and the MII word classification.
// ---------------------------------------------------------------------------
package baser_pkg;

    // MII control characters
    localparam logic [7:0] MII_IDLE  = 8'h07;
    localparam logic [7:0] MII_START = 8'hFB;
    localparam logic [7:0] MII_TERM  = 8'hFD;
    localparam logic [7:0] MII_ERROR = 8'hFE;

    // 7-bit control codes carried inside control blocks
    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;

    // Block-type fields
    localparam logic [7:0] BT_CTRL  = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;

    // Sync headers, transmitted in o_block[1:0]
    localparam logic [1:0] SH_DATA = 2'b10;
    localparam logic [1:0] SH_CTRL = 2'b01;

    // Error block payload: control type followed by eight /E/ codes
    localparam logic [63:0] ERR_PAYLOAD = {{8{CC_ERROR}}, BT_CTRL};

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        W_C = 3'd0,
        W_D = 3'd1,
        W_S = 3'd2,
        W_T = 3'd3,
        W_E = 3'd4
    } word_class_t;

    // Block type for a terminate character in lane k
    function automatic logic [7:0] term_type(input logic [2:0] k);
        case (k)
            3'd0:    return 8'h87;
            3'd1:    return 8'h99;
            3'd2:    return 8'hAA;
            3'd3:    return 8'hB4;
            3'd4:    return 8'hCC;
            3'd5:    return 8'hD2;
            3'd6:    return 8'hE1;
            default: return 8'hFF;
        endcase
    endfunction

    // Byte of MII lane k (lane 0 in the low byte)
    function automatic logic [7:0] mii_lane(input logic [63:0] d, input int unsigned k);
        return d[8*k +: 8];
    endfunction

endpackage

// File: rtl/mii_baser_encoder_if.sv
// ---------------------------------------------------------------------------
// mii_baser_encoder_if
// Bundle between the MII word source and the BASE-R encoder.
//   i_valid     word valid
//   i_mii_data  64-bit MII word, lane k = bits [8k+7:8k]
//   i_mii_ctrl  per-lane control flags
//   o_block     66-bit block, [1:0] sync header, [65:2] payload
//   o_valid     o_block valid
//   o_tx_state  current transmit state
// master: word source / observer; slave: the encoder.
// ---------------------------------------------------------------------------
interface mii_baser_encoder_if;
    import baser_pkg::*;

    logic        i_valid;
    logic [63:0] i_mii_data;
    logic [7:0]  i_mii_ctrl;
    logic [65:0] o_block;
    logic        o_valid;
    tx_state_t   o_tx_state;

    modport master (
        output i_valid, i_mii_data, i_mii_ctrl,
        input  o_block, o_valid, o_tx_state
    );

    modport slave (
        input  i_valid, i_mii_data, i_mii_ctrl,
        output o_block, o_valid, o_tx_state
    );

endinterface

// File: rtl/baser_scrambler.sv
// ---------------------------------------------------------------------------
// baser_scrambler
// 64-bit parallel self-synchronous scrambler, polynomial x^58 + x^39 + 1.
// Serial equivalent, payload LSB first: out = in ^ s[38] ^ s[57], s shifts
// in out.  dout is combinational from din and the held state; the state
// advances only when en is high.
//   clk    clock
//   rst_n  asynchronous active-low reset, loads SCR_SEED
//   en     advance the scrambler state by one 64-bit word
//   din    payload in
//   dout   scrambled payload (din unchanged when SCRAMBLE = 0)
// ---------------------------------------------------------------------------
module baser_scrambler #(
    parameter bit          SCRAMBLE = 1'b1,
    parameter logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    logic [57:0]  state;
    logic [57:0]  state_nxt;
    logic [121:0] ext;
    logic [63:0]  scr;

    // ext is the serial output history laid out oldest-first: ext[0] is the
    // bit sent 58 positions ago (s[57]), ext[57] the most recent (s[0]),
    // ext[58+i] the scrambled payload bit i.  Taps s[38]/s[57] for bit i
    // therefore sit at ext[i+19]/ext[i].
    always_comb begin
        ext = '0;
        for (int unsigned m = 0; m < 58; m++) begin
            ext[57 - m] = state[m];
        end
        for (int unsigned i = 0; i < 64; i++) begin
            ext[58 + i] = din[i] ^ ext[i + 19] ^ ext[i];
        end
        scr = ext[121:58];
        for (int unsigned m = 0; m < 58; m++) begin
            state_nxt[m] = ext[121 - m];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SCR_SEED;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Bypass still keeps the state register running on the scrambled stream.
    assign dout = SCRAMBLE ? scr : din;

endmodule

// File: rtl/mii_baser_encoder.sv
// ---------------------------------------------------------------------------
// mii_baser_encoder
// 64b/66b BASE-R transmit encoder.  Two-stage pipeline:
//   stage 1: classify the MII word, run the transmit FSM, build the block
//   stage 2: scramble the payload (header passes through)
// o_valid is i_valid delayed by two cycles; bubbles hold FSM, scrambler
// and o_block.
//   clk      block clock
//   i_rst_n  asynchronous active-low reset
//   bus      slave side of mii_baser_encoder_if (MII word in, block out)
// ---------------------------------------------------------------------------
module mii_baser_encoder
    import baser_pkg::*;
#(
    parameter bit          SCRAMBLE = 1'b1,
    parameter logic [57:0] SCR_SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    mii_baser_encoder_if.slave bus
);

    tx_state_t   state;
    tx_state_t   state_nxt;
    word_class_t wclass;

    logic        c_ok;
    logic        t_found;
    logic        t_ok;
    logic [2:0]  t_lane;
    logic [1:0]  enc_hdr;
    logic [63:0] enc_pay;
    logic [65:0] blk_nxt;

    logic        s1_valid;
    logic [65:0] s1_block;
    logic [63:0] scr_pay;

    // ---------------- classification ----------------
    always_comb begin
        c_ok    = &bus.i_mii_ctrl;
        t_found = 1'b0;
        t_ok    = 1'b0;
        t_lane  = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (mii_lane(bus.i_mii_data, k) != MII_IDLE &&
                mii_lane(bus.i_mii_data, k) != MII_ERROR) begin
                c_ok = 1'b0;
            end
            // First control lane must be /T/; every later lane must be /I/.
            if (!t_found && bus.i_mii_ctrl[k]) begin
                t_found = 1'b1;
                t_lane  = k[2:0];
                t_ok    = (mii_lane(bus.i_mii_data, k) == MII_TERM);
            end else if (t_found &&
                         !(bus.i_mii_ctrl[k] && mii_lane(bus.i_mii_data, k) == MII_IDLE)) begin
                t_ok = 1'b0;
            end
        end

        if (bus.i_mii_ctrl == 8'h00) begin
            wclass = W_D;
        end else if (bus.i_mii_ctrl == 8'h01 && mii_lane(bus.i_mii_data, 0) == MII_START) begin
            wclass = W_S;
        end else if (c_ok) begin
            wclass = W_C;
        end else if (t_ok) begin
            wclass = W_T;
        end else begin
            wclass = W_E;
        end
    end

    // ---------------- block encoding ----------------
    always_comb begin
        enc_hdr = SH_CTRL;
        enc_pay = '0;
        case (wclass)
            W_D: begin
                enc_hdr = SH_DATA;
                enc_pay = bus.i_mii_data;
            end
            W_S: begin
                enc_pay = {bus.i_mii_data[63:8], BT_START};
            end
            W_C: begin
                enc_pay[7:0] = BT_CTRL;
                for (int unsigned k = 0; k < 8; k++) begin
                    enc_pay[8 + 7*k +: 7] =
                        (mii_lane(bus.i_mii_data, k) == MII_ERROR) ? CC_ERROR : CC_IDLE;
                end
            end
            W_T: begin
                // Pad bits and trailing idle codes are all zero.
                enc_pay[7:0] = term_type(t_lane);
                for (int unsigned j = 0; j < 7; j++) begin
                    if (j < 32'(t_lane)) begin
                        enc_pay[8 + 8*j +: 8] = mii_lane(bus.i_mii_data, j);
                    end
                end
            end
            default: begin
                enc_pay = ERR_PAYLOAD;
            end
        endcase
    end

    // ---------------- transmit FSM next state ----------------
    always_comb begin
        state_nxt = TX_E;
        case (state)
            TX_D: begin
                case (wclass)
                    W_D:     state_nxt = TX_D;
                    W_T:     state_nxt = TX_T;
                    default: state_nxt = TX_E;
                endcase
            end
            TX_E: begin
                case (wclass)
                    W_C:     state_nxt = TX_C;
                    W_D:     state_nxt = TX_D;
                    W_T:     state_nxt = TX_T;
                    W_S:     state_nxt = TX_D;
                    default: state_nxt = TX_E;
                endcase
            end
            default: begin // TX_INIT, TX_C, TX_T
                case (wclass)
                    W_C:     state_nxt = TX_C;
                    W_S:     state_nxt = TX_D;
                    default: state_nxt = TX_E;
                endcase
            end
        endcase

        blk_nxt = (state_nxt == TX_E) ? {ERR_PAYLOAD, SH_CTRL} : {enc_pay, enc_hdr};
    end

    // ---------------- stage 1 ----------------
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= TX_INIT;
            s1_valid <= 1'b0;
            s1_block <= '0;
        end else begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                state    <= state_nxt;
                s1_block <= blk_nxt;
            end
        end
    end

    // ---------------- stage 2 ----------------
    baser_scrambler #(
        .SCRAMBLE (SCRAMBLE),
        .SCR_SEED (SCR_SEED)
    ) u_scrambler (
        .clk   (clk),
        .rst_n (i_rst_n),
        .en    (s1_valid),
        .din   (s1_block[65:2]),
        .dout  (scr_pay)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_valid <= 1'b0;
            bus.o_block <= '0;
        end else begin
            bus.o_valid <= s1_valid;
            if (s1_valid) begin
                bus.o_block <= {scr_pay, s1_block[1:0]};
            end
        end
    end

    assign bus.o_tx_state = state;

endmodule

// File: tb/tb_mii_baser_encoder.sv
// ---------------------------------------------------------------------------
// tb_mii_baser_encoder
// Two encoders, one unscrambled and one scrambled, share the same MII
// stimulus.  Each issued word pushes its hand-computed block (tagged with
// the cycle it must appear) and the expected FSM state into queues; the
// monitor pops them as the DUT presents blocks.  The scrambled instance is
// recovered through a bit-serial reference descrambler.
// ---------------------------------------------------------------------------
module tb_mii_baser_encoder;
    import baser_pkg::*;

    localparam logic [57:0] SEED   = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IDLE_P = 64'h0000_0000_0000_001E;
    localparam logic [63:0] ERR_P  = 64'h3C78_F1E3_C78F_1E1E;
    localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;

    mii_baser_encoder_if b0 ();
    mii_baser_encoder_if b1 ();

    mii_baser_encoder #(.SCRAMBLE(1'b0), .SCR_SEED(SEED)) dut0 (
        .clk(clk), .i_rst_n(rst_n), .bus(b0.slave)
    );
    mii_baser_encoder #(.SCRAMBLE(1'b1), .SCR_SEED(SEED)) dut1 (
        .clk(clk), .i_rst_n(rst_n), .bus(b1.slave)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  hdr;
        logic [63:0] pay;
    } blk_exp_t;

    typedef struct {
        int        cyc;
        tx_state_t st;
    } st_exp_t;

    blk_exp_t bq[$];
    st_exp_t  sq[$];
    logic [57:0] dscr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bit-serial reference descrambler; returns {new_state, payload}.
    function automatic logic [121:0] descr(input logic [57:0] s, input logic [63:0] rx);
        logic [57:0] d;
        logic [63:0] o;
        d = s;
        for (int i = 0; i < 64; i++) begin
            o[i] = rx[i] ^ d[38] ^ d[57];
            d    = {d[56:0], rx[i]};
        end
        return {d, o};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        blk_exp_t     be;
        st_exp_t      se;
        logic [121:0] r;
        if (!rst_n) begin
            dscr = SEED;
        end else begin
            if (sq.size() != 0 && sq[0].cyc <= cyc) begin
                se = sq.pop_front();
                chk("tx_state_dut0", 66'(b0.o_tx_state), 66'(se.st));
                chk("tx_state_dut1", 66'(b1.o_tx_state), 66'(se.st));
            end
            if (b0.o_valid) begin
                if (bq.size() == 0) begin
                    chk("unexpected_valid", 66'd1, 66'd0);
                end else begin
                    be = bq.pop_front();
                    chk("latency", 66'(cyc), 66'(be.cyc));
                    chk("block_dut0", b0.o_block, {be.pay, be.hdr});
                    chk("valid_dut1", 66'(b1.o_valid), 66'd1);
                    chk("hdr_dut1", 66'(b1.o_block[1:0]), 66'(be.hdr));
                    r    = descr(dscr, b1.o_block[65:2]);
                    dscr = r[121:64];
                    chk("descrambled_dut1", 66'(r[63:0]), 66'(be.pay));
                end
            end else begin
                if (b1.o_valid) chk("dut1_spurious_valid", 66'd1, 66'd0);
                if (bq.size() != 0 && bq[0].cyc < cyc) begin
                    be = bq.pop_front();
                    chk("missing_block", 66'(cyc), 66'(be.cyc));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [7:0] c, input logic [63:0] d);
        b0.i_valid = v; b0.i_mii_ctrl = c; b0.i_mii_data = d;
        b1.i_valid = v; b1.i_mii_ctrl = c; b1.i_mii_data = d;
    endtask

    task automatic send(input logic [7:0] c, input logic [63:0] d,
                        input logic [1:0] h, input logic [63:0] p, input tx_state_t s);
        blk_exp_t be;
        st_exp_t  se;
        @(posedge clk); #1;
        drive(1'b1, c, d);
        be.cyc = cyc + 2; be.hdr = h; be.pay = p;
        se.cyc = cyc + 1; se.st = s;
        bq.push_back(be);
        sq.push_back(se);
    endtask

    task automatic bubble();
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 64'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive(1'b0, 8'h00, 64'h0);
        rst_n = 1'b0;
        #1;
        chk("rst_valid_dut0", 66'(b0.o_valid), 66'd0);
        chk("rst_block_dut0", b0.o_block, 66'd0);
        chk("rst_state_dut0", 66'(b0.o_tx_state), 66'(TX_INIT));
        chk("rst_valid_dut1", 66'(b1.o_valid), 66'd0);
        chk("rst_block_dut1", b1.o_block, 66'd0);
        bq.delete();
        sq.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        dscr     = SEED;
        drive(1'b0, 8'h00, 64'h0);
        rst_n = 1'b1;
        do_reset();

        // idle, start, data, bubbles, data, terminate lane 3
        repeat (3) send(8'hFF, IDLE_W, SH_CTRL, IDLE_P, TX_C);
        send(8'h01, 64'hD555_5555_5555_55FB, SH_CTRL, 64'hD555_5555_5555_5578, TX_D);
        send(8'h00, 64'h0123_4567_89AB_CDEF, SH_DATA, 64'h0123_4567_89AB_CDEF, TX_D);
        repeat (3) bubble();
        send(8'h00, 64'hFEDC_BA98_7654_3210, SH_DATA, 64'hFEDC_BA98_7654_3210, TX_D);
        send(8'hF8, 64'h0707_0707_FDCC_BBAA, SH_CTRL, 64'h0000_0000_CCBB_AAB4, TX_T);

        // idle carrying an /E/ lane, illegal C->D, recovery via E->D
        send(8'hFF, IDLE_W, SH_CTRL, IDLE_P, TX_C);
        send(8'hFF, 64'h0707_07FE_0707_0707, SH_CTRL, 64'h0000_01E0_0000_001E, TX_C);
        send(8'h00, 64'h1111_1111_1111_1111, SH_CTRL, ERR_P, TX_E);
        send(8'h00, 64'h2222_2222_2222_2222, SH_DATA, 64'h2222_2222_2222_2222, TX_D);

        // terminate boundaries: lane 0 and lane 7
        send(8'hFF, 64'h0707_0707_0707_07FD, SH_CTRL, 64'h0000_0000_0000_0087, TX_T);
        send(8'h01, 64'h0102_0304_0506_07FB, SH_CTRL, 64'h0102_0304_0506_0778, TX_D);
        send(8'h80, 64'hFD66_5544_3322_1100, SH_CTRL, 64'h6655_4433_2211_00FF, TX_T);

        // /S/ in lane 2, then another invalid word while in E, idle recovers
        send(8'h01, 64'hAAAA_AAAA_AAAA_AAFB, SH_CTRL, 64'hAAAA_AAAA_AAAA_AA78, TX_D);
        send(8'h04, 64'h1111_1111_11FB_1111, SH_CTRL, ERR_P, TX_E);
        send(8'h10, 64'h0000_0007_0000_0000, SH_CTRL, ERR_P, TX_E);
        send(8'hFF, IDLE_W, SH_CTRL, IDLE_P, TX_C);

        // terminate straight after idle is illegal
        send(8'hFF, 64'h0707_0707_0707_07FD, SH_CTRL, ERR_P, TX_E);
        send(8'hFF, IDLE_W, SH_CTRL, IDLE_P, TX_C);

        // reset mid-frame; a data word from INIT becomes an error block
        send(8'h01, 64'hD555_5555_5555_55FB, SH_CTRL, 64'hD555_5555_5555_5578, TX_D);
        send(8'h00, 64'h4444_4444_4444_4444, SH_DATA, 64'h4444_4444_4444_4444, TX_D);
        do_reset();
        send(8'h00, 64'h3333_3333_3333_3333, SH_CTRL, ERR_P, TX_E);
        send(8'hFF, IDLE_W, SH_CTRL, IDLE_P, TX_C);

        // long idle run through the scrambled instance
        repeat (100) send(8'hFF, IDLE_W, SH_CTRL, IDLE_P, TX_C);
        bubble();

        for (int i = 0; i < 20 && (bq.size() != 0 || sq.size() != 0); i++) begin
            @(posedge clk);
        end
        @(posedge clk); #1;
        chk("drain_blocks", 66'(bq.size()), 66'd0);
        chk("drain_states", 66'(sq.size()), 66'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
